comp_page_dispatcher: RTL and testbench

- Distributes fixed-size 4 KiB pages from a single input AXI stream across N compression cores.
- Each page goes to an idle core under rotating priority. The chosen core id is recorded in an order FIFO.
- Compressed results are gathered back from the cores in original page order.
- Sits between the host/SSD data path and the compression core array.

---
 rtl/comp_page_dispatcher.sv | 198 +++++++++++++++++++
 tb/tb_comp_page_dispatcher.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_page_dispatcher.sv
// Page dispatcher: spreads fixed-size pages across N compression cores and
// gathers results back in page order. Optional framing check: PAGE_CHECK_EN.
module comp_page_dispatcher #(
  parameter int N_CORES     = 2,
  parameter int DATA_BITS   = 512,
  parameter int PAGE_BEATS  = 64,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic [DATA_BITS-1:0]           s_in_tdata,
  input  logic                           s_in_tvalid,
  output logic                           s_in_tready,
  input  logic                           s_in_tlast,
  input  logic [N_CORES-1:0]             core_idle,
  output logic [DATA_BITS-1:0]           m_core_tdata,
  output logic [N_CORES-1:0]             m_core_tvalid,
  input  logic [N_CORES-1:0]             m_core_tready,
  output logic                           m_core_tlast,
  input  logic [N_CORES*DATA_BITS-1:0]   s_core_tdata,
  input  logic [N_CORES-1:0]             s_core_tvalid,
  output logic [N_CORES-1:0]             s_core_tready,
  input  logic [N_CORES-1:0]             s_core_tlast,
  output logic [DATA_BITS-1:0]           m_out_tdata,
  output logic                           m_out_tvalid,
  input  logic                           m_out_tready,
  output logic                           m_out_tlast,
  output logic [31:0]                    pages_in,
  output logic [31:0]                    pages_out,
  output logic                           proto_err,
  output logic [1:0]                     dbg_state_o
);

  // Handshakes: a beat moves when valid and ready are both high on a rising
  // edge; valid never waits on ready, ready may depend on valid's target.

  localparam int IDW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int BCW = (PAGE_BEATS > 1) ? $clog2(PAGE_BEATS) : 1;
  localparam int AW  = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;

  typedef enum logic {D_SELECT = 1'b0, D_STREAM = 1'b1} d_state_t;
  typedef enum logic {C_IDLE = 1'b0, C_STREAM = 1'b1} c_state_t;

  d_state_t       d_state_q, d_state_d;
  c_state_t       c_state_q, c_state_d;
  logic [IDW-1:0] sel_q, sel_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] cur_q, cur_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [31:0]    pages_in_q, pages_in_d;
  logic [31:0]    pages_out_q, pages_out_d;

  logic [IDW-1:0] fifo_mem [ORDER_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    cnt_q;
  logic           fifo_full, fifo_empty, push, pop, in_hs;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  assign fifo_full  = (cnt_q == (AW+1)'(ORDER_DEPTH));
  assign fifo_empty = (cnt_q == '0);

  // Rotating priority: first idle core at or after rr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (!pick_found && core_idle[(int'(rr_q) + k) % N_CORES]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'((int'(rr_q) + k) % N_CORES);
      end
    end
  end

  assign m_core_tdata = s_in_tdata;

  always_comb begin
    d_state_d     = d_state_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    beat_d        = beat_q;
    pages_in_d    = pages_in_q;
    push          = 1'b0;
    in_hs         = 1'b0;
    s_in_tready   = 1'b0;
    m_core_tvalid = '0;
    m_core_tlast  = (beat_q == BCW'(PAGE_BEATS - 1));
    case (d_state_q)
      D_SELECT: begin
        if (s_in_tvalid && !fifo_full && pick_found) begin
          push      = 1'b1;
          sel_d     = pick_idx;
          rr_d      = IDW'((int'(pick_idx) + 1) % N_CORES);
          d_state_d = D_STREAM;
        end
      end
      D_STREAM: begin
        m_core_tvalid[sel_q] = s_in_tvalid;
        s_in_tready          = m_core_tready[sel_q];
        in_hs                = s_in_tvalid && m_core_tready[sel_q];
        if (in_hs) begin
          if (m_core_tlast) begin
            beat_d     = '0;
            pages_in_d = pages_in_q + 32'd1;
            d_state_d  = D_SELECT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: d_state_d = D_SELECT;
    endcase
  end

  // The FIFO entry stays at the head until the page's last result beat.
  always_comb begin
    c_state_d     = c_state_q;
    cur_d         = cur_q;
    pages_out_d   = pages_out_q;
    pop           = 1'b0;
    s_core_tready = '0;
    m_out_tvalid  = 1'b0;
    m_out_tlast   = 1'b0;
    m_out_tdata   = '0;
    case (c_state_q)
      C_IDLE: begin
        if (!fifo_empty) begin
          cur_d     = fifo_mem[rd_ptr_q];
          c_state_d = C_STREAM;
        end
      end
      C_STREAM: begin
        m_out_tvalid         = s_core_tvalid[cur_q];
        m_out_tlast          = s_core_tlast[cur_q];
        m_out_tdata          = s_core_tdata[int'(cur_q)*DATA_BITS +: DATA_BITS];
        s_core_tready[cur_q] = m_out_tready;
        if (s_core_tvalid[cur_q] && m_out_tready && s_core_tlast[cur_q]) begin
          pop         = 1'b1;
          pages_out_d = pages_out_q + 32'd1;
          c_state_d   = C_IDLE;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      d_state_q   <= D_SELECT;
      c_state_q   <= C_IDLE;
      sel_q       <= '0;
      rr_q        <= '0;
      cur_q       <= '0;
      beat_q      <= '0;
      pages_in_q  <= '0;
      pages_out_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      d_state_q   <= d_state_d;
      c_state_q   <= c_state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      cur_q       <= cur_d;
      beat_q      <= beat_d;
      pages_in_q  <= pages_in_d;
      pages_out_q <= pages_out_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q] <= pick_idx;
  end

`ifdef PAGE_CHECK_EN
  logic proto_err_q;
  always_ff @(posedge aclk) begin
    if (reset)                                    proto_err_q <= 1'b0;
    else if (in_hs && (s_in_tlast != m_core_tlast)) proto_err_q <= 1'b1;
  end
  assign proto_err = proto_err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_in_tlast;
  assign proto_err    = 1'b0;
`endif

  assign pages_in    = pages_in_q;
  assign pages_out   = pages_out_q;
  assign dbg_state_o = {c_state_q, d_state_q};

endmodule

// File: tb/tb_comp_page_dispatcher.sv
// Directed bench for comp_page_dispatcher: 2 cores, 32-bit data, 64-beat
// pages, order FIFO depth 2, with a per-cycle core/sink model and scoreboard.
module tb_comp_page_dispatcher;

  localparam int NC = 2;
  localparam int DW = 32;
  localparam int PB = 64;
`ifdef PAGE_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic             aclk = 1'b0;
  logic             reset;
  logic [DW-1:0]    s_in_tdata;
  logic             s_in_tvalid, s_in_tready, s_in_tlast;
  logic [NC-1:0]    core_idle;
  logic [DW-1:0]    m_core_tdata;
  logic [NC-1:0]    m_core_tvalid, m_core_tready;
  logic             m_core_tlast;
  logic [NC*DW-1:0] s_core_tdata;
  logic [NC-1:0]    s_core_tvalid, s_core_tready, s_core_tlast;
  logic [DW-1:0]    m_out_tdata;
  logic             m_out_tvalid, m_out_tready, m_out_tlast;
  logic [31:0]      pages_in, pages_out;
  logic             proto_err;
  logic [1:0]       dbg_state_o;

  comp_page_dispatcher #(.N_CORES(NC), .DATA_BITS(DW), .PAGE_BEATS(PB), .ORDER_DEPTH(2)) dut (
    .aclk(aclk), .reset(reset),
    .s_in_tdata(s_in_tdata), .s_in_tvalid(s_in_tvalid), .s_in_tready(s_in_tready),
    .s_in_tlast(s_in_tlast), .core_idle(core_idle),
    .m_core_tdata(m_core_tdata), .m_core_tvalid(m_core_tvalid),
    .m_core_tready(m_core_tready), .m_core_tlast(m_core_tlast),
    .s_core_tdata(s_core_tdata), .s_core_tvalid(s_core_tvalid),
    .s_core_tready(s_core_tready), .s_core_tlast(s_core_tlast),
    .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid),
    .m_out_tready(m_out_tready), .m_out_tlast(m_out_tlast),
    .pages_in(pages_in), .pages_out(pages_out), .proto_err(proto_err),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  // bench model state
  logic [DW-1:0] src_q[$];
  logic [DW+1:0] res_q[$];       // {core, last, data}
  logic [DW:0]   exp_q[$];       // {last, data}
  int            exp_core_q[$];
  int            in_beat, bad_beat, res_len, out_pages, out_beats;
  int            rcv_beat[NC], rcv_pages[NC];
  bit            src_en, rdy_rand, out_last_now;
  bit [NC-1:0]   res_en;
  logic          obs_s_in_tready, obs_m_out_tvalid;
  logic [NC-1:0] obs_m_core_tvalid, obs_s_core_tready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_page(input int pid);
    for (int b = 0; b < PB; b++) src_q.push_back({16'(pid), 16'(b)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_in_tvalid = 1'b1; s_in_tdata = '0; s_in_tlast = 1'b0;
    core_idle = '1; m_core_tready = '1; m_out_tready = 1'b1;
    s_core_tvalid = '1; s_core_tlast = '1; s_core_tdata = '0;
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_s_in_tready", s_in_tready, 0);
    check_eq("rst_m_core_tvalid", m_core_tvalid, 0);
    check_eq("rst_s_core_tready", s_core_tready, 0);
    check_eq("rst_m_out_tvalid", m_out_tvalid, 0);
    check_eq("rst_pages_in", pages_in, 0);
    check_eq("rst_pages_out", pages_out, 0);
    check_eq("rst_proto_err", proto_err, 0);
    check_eq("rst_state", dbg_state_o, 0);
    reset = 1'b0;
    s_in_tvalid = 1'b0; s_core_tvalid = '0; s_core_tlast = '0;
    src_q.delete(); res_q.delete(); exp_q.delete(); exp_core_q.delete();
    in_beat = 0; bad_beat = -1; res_len = 1; out_pages = 0; out_beats = 0;
    src_en = 1'b1; rdy_rand = 1'b0; res_en = '1; core_idle = '1;
    for (int i = 0; i < NC; i++) begin rcv_beat[i] = 0; rcv_pages[i] = 0; end
  endtask

  // driver + core/sink model for one clock cycle
  task automatic cycle();
    int idx[NC];
    int pid, len, d0, d1;
    logic ihs, ohs;
    logic [NC-1:0] chs, exp_tr;
    logic [DW-1:0] rd;
    s_in_tvalid   = src_en && (src_q.size() > 0);
    s_in_tdata    = (src_q.size() > 0) ? src_q[0] : '0;
    s_in_tlast    = (in_beat == PB - 1) || (in_beat == bad_beat);
    m_core_tready = rdy_rand ? 2'($urandom_range(0, 3)) : 2'b11;
    m_out_tready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < NC; i++) begin
      idx[i] = -1;
      if (res_en[i])
        for (int k = 0; k < res_q.size(); k++)
          if (idx[i] < 0 && int'(res_q[k][DW+1]) == i) idx[i] = k;
      s_core_tvalid[i]       = (idx[i] >= 0);
      s_core_tlast[i]        = (idx[i] >= 0) ? res_q[idx[i]][DW] : 1'b0;
      s_core_tdata[i*DW +: DW] = (idx[i] >= 0) ? res_q[idx[i]][DW-1:0] : '0;
    end
    #1;
    obs_s_in_tready = s_in_tready; obs_m_core_tvalid = m_core_tvalid;
    obs_s_core_tready = s_core_tready; obs_m_out_tvalid = m_out_tvalid;
    ihs = s_in_tvalid && s_in_tready;
    chs = m_core_tvalid & m_core_tready;
    if (m_core_tvalid != 0) check_eq("core_valid_onehot", $countones(m_core_tvalid), 1);
    if (ihs || chs != 0) check_eq("hs_pair", ihs, |chs);
    for (int i = 0; i < NC; i++) begin
      if (chs[i]) begin
        check_eq("core_data", m_core_tdata, (src_q.size() > 0) ? src_q[0] : '0);
        check_eq("core_tlast", m_core_tlast, rcv_beat[i] == PB - 1);
        if (rcv_beat[i] == 0) exp_core_q.push_back(i);
        if (rcv_beat[i] == PB - 1) begin
          rcv_beat[i] = 0;
          rcv_pages[i]++;
          pid = int'(m_core_tdata[31:16]);
          len = (res_len > 0) ? res_len : 1 + pid % 7;
          for (int k = 0; k < len; k++) begin
            rd = 32'h5A5A0000 ^ {16'(pid), 16'(k)};
            res_q.push_back({1'(i), k == len - 1, rd});
            exp_q.push_back({k == len - 1, rd});
          end
        end else begin
          rcv_beat[i]++;
        end
      end
    end
    if (ihs) begin
      void'(src_q.pop_front());
      in_beat = (in_beat + 1) % PB;
    end
    if (exp_core_q.size() > 0) begin
      exp_tr = 2'b01 << exp_core_q[0];
      check_eq("core_ready_head", s_core_tready & ~exp_tr, 0);
    end
    ohs = m_out_tvalid && m_out_tready;
    out_last_now = 1'b0;
    if (ohs) begin
      if (exp_q.size() == 0) begin
        check_eq("out_extra_beat", {m_out_tlast, m_out_tdata}, {1'b0, 32'hDEAD_BEEF});
      end else begin
        check_eq("out_beat", {m_out_tlast, m_out_tdata}, exp_q[0]);
        out_beats++;
        if (exp_q[0][DW]) begin
          out_pages++;
          out_last_now = 1'b1;
          if (exp_core_q.size() > 0) void'(exp_core_q.pop_front());
        end
        void'(exp_q.pop_front());
      end
    end
    d0 = (s_core_tvalid[0] && s_core_tready[0]) ? idx[0] : -1;
    d1 = (s_core_tvalid[1] && s_core_tready[1]) ? idx[1] : -1;
    if (d0 > d1) begin
      res_q.delete(d0);
      if (d1 >= 0) res_q.delete(d1);
    end else begin
      if (d1 >= 0) res_q.delete(d1);
      if (d0 >= 0) res_q.delete(d0);
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    do_reset();

    // single page to core0, 10-beat result
    res_len = 10;
    add_page(1);
    cycle();
    check_eq("t1_select_no_ready", obs_s_in_tready, 0);
    check_eq("t1_select_no_valid", obs_m_core_tvalid, 0);
    cycle();
    check_eq("t1_core0_valid", obs_m_core_tvalid, 2'b01);
    for (int c = 0; c < 300 && out_pages < 1; c++) cycle();
    check_eq("t1_out_pages", out_pages, 1);
    check_eq("t1_out_beats", out_beats, 10);
    check_eq("t1_core0_pages", rcv_pages[0], 1);
    check_eq("t1_core1_pages", rcv_pages[1], 0);
    check_eq("t1_pages_in", pages_in, 1);
    check_eq("t1_pages_out", pages_out, 1);

    // reordering: core1 result offered first must wait for core0
    do_reset();
    res_en = 2'b00; res_len = 4;
    add_page(2); add_page(3);
    for (int c = 0; c < 400 && rcv_pages[0] + rcv_pages[1] < 2; c++) cycle();
    check_eq("t2_core0_pages", rcv_pages[0], 1);
    check_eq("t2_core1_pages", rcv_pages[1], 1);
    check_eq("t2_pages_in", pages_in, 2);
    res_en = 2'b10;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check_eq("t2_core1_held", obs_s_core_tready[1], 0);
      check_eq("t2_out_idle", obs_m_out_tvalid, 0);
    end
    res_en = 2'b11;
    for (int c = 0; c < 100 && out_pages < 2; c++) cycle();
    check_eq("t2_out_pages", out_pages, 2);
    check_eq("t2_pages_out", pages_out, 2);

    // no idle core, then core1 only
    do_reset();
    core_idle = 2'b00; res_len = 3;
    add_page(4);
    for (int c = 0; c < 20; c++) begin
      cycle();
      check_eq("t3_stalled", {obs_s_in_tready, obs_m_core_tvalid}, 0);
    end
    core_idle = 2'b10;
    cycle();
    check_eq("t3_select_cycle", obs_m_core_tvalid, 2'b00);
    cycle();
    check_eq("t3_core1_valid", obs_m_core_tvalid, 2'b10);
    for (int c = 0; c < 300 && out_pages < 1; c++) cycle();
    check_eq("t3_core1_pages", rcv_pages[1], 1);
    check_eq("t3_pages_in", pages_in, 1);
    check_eq("t3_pages_out", pages_out, 1);

    // order FIFO full (depth 2): third page waits for a pop
    do_reset();
    res_en = 2'b00; res_len = 2;
    add_page(5); add_page(6); add_page(7);
    for (int c = 0; c < 400 && rcv_pages[0] + rcv_pages[1] < 2; c++) cycle();
    repeat (30) cycle();
    check_eq("t4_full_no_ready", obs_s_in_tready, 0);
    check_eq("t4_full_no_valid", obs_m_core_tvalid, 0);
    check_eq("t4_pages_in", pages_in, 2);
    check_eq("t4_dispatch_select", dbg_state_o[0], 0);
    res_en = 2'b01;
    for (int c = 0; c < 20 && !out_last_now; c++) cycle();
    check_eq("t4_core0_returned", out_pages, 1);
    cycle();
    check_eq("t4_select_after_pop", obs_m_core_tvalid, 2'b00);
    cycle();
    check_eq("t4_third_to_core0", obs_m_core_tvalid, 2'b01);
    res_en = 2'b11;
    for (int c = 0; c < 400 && out_pages < 3; c++) cycle();
    check_eq("t4_pages_in_end", pages_in, 3);
    check_eq("t4_pages_out_end", pages_out, 3);

    // random backpressure, 16 pages with varied result lengths
    do_reset();
    rdy_rand = 1'b1; res_len = 0;
    for (int p = 16; p < 32; p++) add_page(p);
    for (int c = 0; c < 20000 && out_pages < 16; c++) cycle();
    check_eq("t5_out_pages", out_pages, 16);
    check_eq("t5_pages_in", pages_in, 16);
    check_eq("t5_pages_out", pages_out, 16);
    check_eq("t5_exp_empty", exp_q.size(), 0);
    check_eq("t5_src_empty", src_q.size(), 0);

    // early tlast on beat 10
    do_reset();
    bad_beat = 10; res_len = 1;
    add_page(40);
    for (int c = 0; c < 100 && in_beat < 10; c++) cycle();
    check_eq("t6_err_before", proto_err, 0);
    cycle();
    check_eq("t6_beat10_taken", in_beat, 11);
    check_eq("t6_err_after", proto_err, EXP_ERR);
    for (int c = 0; c < 200 && out_pages < 1; c++) cycle();
    check_eq("t6_full_page", rcv_pages[0], 1);
    check_eq("t6_err_sticky", proto_err, EXP_ERR);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
